// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// mult_pkg : digit width and FSM encoding shared by the sequential Vedic multiplier
// Rev 1.0
// ============================================================================
package mult_pkg;

  localparam int DIGIT_W = 8;
  localparam int PP_W    = 2 * DIGIT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for n digits; a single-digit operand still needs a 1-bit counter.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_vedic_8bit.sv
`default_nettype none
// ============================================================================
// simple_vedic_8bit : combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier
// Rev 1.0
// ============================================================================
module simple_vedic_8bit (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic p00, p01, p10, p11, c1;
    p00 = x[0] & y[0];
    p10 = x[1] & y[0];
    p01 = x[0] & y[1];
    p11 = x[1] & y[1];
    c1  = p10 & p01;
    return {p11 & c1, p11 ^ c1, p10 ^ p01, p00};
  endfunction

  // Each level combines four half-width cross products, vertically and crosswise.
  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic2(x[1:0], y[1:0]);
    q1 = vedic2(x[3:2], y[1:0]);
    q2 = vedic2(x[1:0], y[3:2]);
    q3 = vedic2(x[3:2], y[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] q0, q1, q2, q3;
    q0 = vedic4(x[3:0], y[3:0]);
    q1 = vedic4(x[7:4], y[3:0]);
    q2 = vedic4(x[3:0], y[7:4]);
    q3 = vedic4(x[7:4], y[7:4]);
    return {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
  endfunction

  assign p_o = vedic8(a_i, b_i);

endmodule
`default_nettype wire

// File: rtl/mult_seq_vedic.sv
`default_nettype none
// ============================================================================
// mult_seq_vedic : sequential unsigned multiplier, one 8x8 Vedic digit product per cycle
// Rev 1.0
// ============================================================================
module mult_seq_vedic
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [2*WIDTH-1:0]   s
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = ctr_width(N);
  localparam int AW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     i_q, i_d;
  logic [CW-1:0]     j_q, j_d;
  logic              i_ready_q, i_ready_d;

  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [PP_W-1:0]    pp;
  logic [AW-1:0]      pp_sh;

  assign a_dig = a_q[int'(i_q) * DIGIT_W +: DIGIT_W];
  assign b_dig = b_q[int'(j_q) * DIGIT_W +: DIGIT_W];

  simple_vedic_8bit u_digit_mul (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_o (pp)
  );

  // Full-width add so the carry out of every partial product reaches the top of acc.
  assign pp_sh = AW'(pp) << (DIGIT_W * (int'(i_q) + int'(j_q)));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid && i_ready_q) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_q + pp_sh;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (o_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign i_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      i_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      i_ready_q <= i_ready_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = (state_q == ST_DONE);
  assign s       = acc_q;

endmodule
`default_nettype wire

// File: doc/mult_seq_vedic.md
MULT_SEQ_VEDIC -- requirements
Module: mult_seq_vedic

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values 8, 16, 24, ..., 64 (multiple of 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port i_valid  input  1  operand pair a/b valid.
REQ-005 SHALL have port i_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-008 SHALL have port o_valid  output  1  product s valid.
REQ-009 SHALL have port o_ready  input  1  consumer accepts s.
REQ-010 SHALL have port s  output  2*WIDTH  unsigned product a*b.

Function
REQ-011 SHALL compute s = a*b exactly, unsigned, with no truncation; N = WIDTH/8 digits per operand.
REQ-012 SHALL use one 8x8 multiplier instance, one partial product per cycle, N*N cycles per product.
REQ-013 SHALL use FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE: i_ready=1 and o_valid=0; i_valid&i_ready at a clk edge SHALL capture a and b, clear acc, set i=j=0, and go to CALC.
REQ-015 CALC: each cycle acc += (a digit i * b digit j) << 8*(i+j); j is the inner counter (0..N-1), i is the outer counter; i_ready=0.
REQ-016 After the pair (N-1,N-1) is accumulated, the FSM SHALL go to DONE on that same edge.
REQ-017 o_valid SHALL rise exactly N*N cycles after the accepting edge (16 for WIDTH=32, 1 for WIDTH=8).
REQ-018 DONE: o_valid=1 and s=acc, held stable while o_ready=0; i_valid SHALL be ignored.
REQ-019 DONE with o_ready=1 at an edge SHALL drop o_valid and return to IDLE; i_ready SHALL be 1 in the following cycle.
REQ-020 The accumulator SHALL be 2*WIDTH bits; the carry out of each 16-bit partial product SHALL propagate fully.
REQ-021 a and b changing after capture SHALL NOT affect the result in progress.
REQ-022 i_ready SHALL be a registered output; i_ready and o_valid SHALL never be 1 in the same cycle.

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE, i_ready=0, o_valid=0, acc=0, and i=j=0, overriding any handshake in that cycle.
REQ-024 i_ready SHALL become 1 at the first edge with rst_n=1.
REQ-025 Reset during CALC or DONE SHALL discard the operation; no o_valid pulse SHALL follow.

Structure
REQ-026 Digit width (8) and the FSM state encodings SHALL live in a shared package, mult_pkg; WIDTH stays a module parameter.
REQ-027 SHALL instantiate the existing simple_vedic_8bit as its sole sub-module for the 8x8 digit product.
REQ-028 The digit multiplexers, shift/add, counters and FSM SHALL be in this module; the product path is combinational from the digit registers into acc.

Verification
REQ-029 WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF -> s=0xFFFFFFFE00000001, with o_valid rising 16 cycles after acceptance.
REQ-030 WIDTH=32: a=0x00010000, b=0x00010000 -> s=0x0000000100000000; a=0, b=0xDEADBEEF -> s=0.
REQ-031 Hold o_ready=0 for 5 cycles in DONE, toggling a/b/i_valid -> s is stable, i_ready=0, and exactly one transfer occurs when o_ready=1.
REQ-032 Assert rst_n=0 for 1 cycle at CALC cycle 7 -> o_valid stays 0, i_ready=1 one cycle after release, and the next operation (a=3, b=5) gives s=15.
REQ-033 10,000 random back-to-back operations with random o_ready stalls, for WIDTH in {8, 32, 64}, scoreboarded against a*b -> zero mismatches and no lost or duplicated results.
